// File: rtl/cplx_twiddle_mult_if.sv
// Bundles the sample/twiddle input stream, the product output stream and the
// overflow flag of cplx_twiddle_mult.
interface cplx_twiddle_mult_if #(
  parameter int DATA_W = 25,
  parameter int TW_W   = 18,
  parameter int OUT_W  = 25
);
  logic [2*DATA_W-1:0] stage_i;
  logic [2*TW_W-1:0]   w_i;
  logic                conj_i;
  logic                data_valid_i;
  logic                data_ready_o;
  logic [2*OUT_W-1:0]  butterfly_stage_o;
  logic                data_valid_o;
  logic                data_ready_i;
  logic                ovf_o;
  logic                ovf_clr_i;

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; valid never waits on ready, and a source holding valid keeps its data.
  modport slave (
    input  stage_i, w_i, conj_i, data_valid_i, data_ready_i, ovf_clr_i,
    output data_ready_o, butterfly_stage_o, data_valid_o, ovf_o
  );

  modport master (
    output stage_i, w_i, conj_i, data_valid_i, data_ready_i, ovf_clr_i,
    input  data_ready_o, butterfly_stage_o, data_valid_o, ovf_o
  );
endinterface

// File: rtl/cplx_twiddle_mult.sv
// Four-stage complex sample x twiddle multiplier (optionally by conj(w)) with
// round/saturate output stage and a single global stall.
module cplx_twiddle_mult #(
  parameter int DATA_W   = 25,
  parameter int TW_W     = 18,
  parameter int TW_FRAC  = 16,
  parameter int OUT_W    = 25,
  parameter int ROUND_EN = 1,
  parameter int SAT_EN   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cplx_twiddle_mult_if.slave bus
);
  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 1;
  localparam logic [SW:0] HALF = (ROUND_EN != 0) ? ((SW+1)'(1) << (TW_FRAC - 1)) : '0;

  logic                     r_s1_valid, r_s1_conj;
  logic signed [DATA_W-1:0] r_s1_xr, r_s1_xi;
  logic signed [TW_W-1:0]   r_s1_wr, r_s1_wi;
  logic                     r_s2_valid, r_s2_conj;
  logic signed [PW-1:0]     r_s2_rr, r_s2_ii, r_s2_ri, r_s2_ir;
  logic                     r_s3_valid;
  logic [SW-1:0]            r_s3_re, r_s3_im;
  logic                     r_s4_valid;
  logic [OUT_W-1:0]         r_out_re, r_out_im;
  logic                     r_ovf;

  logic                     w_stall, w_en, w_new_ovf;
  logic signed [PW-1:0]     w_xr_e, w_xi_e, w_wr_e, w_wi_e;
  logic [SW-1:0]            w_rr, w_ii, w_ri, w_ir, w_re, w_im;
  logic [OUT_W:0]           w_sc_re, w_sc_im;

  assign w_stall               = r_s4_valid & ~bus.data_ready_i;
  assign w_en                  = ~w_stall;
  assign bus.data_ready_o      = w_en;
  assign bus.data_valid_o      = r_s4_valid;
  assign bus.butterfly_stage_o = {r_out_re, r_out_im};
  assign bus.ovf_o             = r_ovf;

  // Operands widened to the full product width so each product is exact.
  assign w_xr_e = {{TW_W{r_s1_xr[DATA_W-1]}}, r_s1_xr};
  assign w_xi_e = {{TW_W{r_s1_xi[DATA_W-1]}}, r_s1_xi};
  assign w_wr_e = {{DATA_W{r_s1_wr[TW_W-1]}}, r_s1_wr};
  assign w_wi_e = {{DATA_W{r_s1_wi[TW_W-1]}}, r_s1_wi};

  assign w_rr = {r_s2_rr[PW-1], r_s2_rr};
  assign w_ii = {r_s2_ii[PW-1], r_s2_ii};
  assign w_ri = {r_s2_ri[PW-1], r_s2_ri};
  assign w_ir = {r_s2_ir[PW-1], r_s2_ir};
  // Conjugate mode flips the sign of every term that carries wi.
  assign w_re = r_s2_conj ? (w_rr + w_ii) : (w_rr - w_ii);
  assign w_im = r_s2_conj ? (w_ir - w_ri) : (w_ir + w_ri);

  // Returns {overflow, value}: optional half-LSB bias, floor shift, clamp or wrap.
  function automatic logic [OUT_W:0] scale(input logic [SW-1:0] s);
    logic [SW:0]            rounded;
    logic signed [SW:0]     shifted;
    logic [SW-OUT_W+1:0]    hi;
    logic                   ovf;
    logic [OUT_W-1:0]       val;
    rounded = {s[SW-1], s} + HALF;
    shifted = $signed(rounded) >>> TW_FRAC;
    hi      = shifted[SW:OUT_W-1];
    ovf     = ~((&hi) | ~(|hi));
    if (ovf && (SAT_EN != 0))
      val = shifted[SW] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      val = shifted[OUT_W-1:0];
    return {ovf, val};
  endfunction

  assign w_sc_re   = scale(r_s3_re);
  assign w_sc_im   = scale(r_s3_im);
  assign w_new_ovf = w_en & r_s3_valid & (w_sc_re[OUT_W] | w_sc_im[OUT_W]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_conj  <= 1'b0;
      r_s1_xr    <= '0;
      r_s1_xi    <= '0;
      r_s1_wr    <= '0;
      r_s1_wi    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_conj  <= 1'b0;
      r_s2_rr    <= '0;
      r_s2_ii    <= '0;
      r_s2_ri    <= '0;
      r_s2_ir    <= '0;
      r_s3_valid <= 1'b0;
      r_s3_re    <= '0;
      r_s3_im    <= '0;
      r_s4_valid <= 1'b0;
      r_out_re   <= '0;
      r_out_im   <= '0;
    end else if (w_en) begin
      r_s1_valid <= bus.data_valid_i;
      r_s1_conj  <= bus.conj_i;
      r_s1_xr    <= bus.stage_i[2*DATA_W-1:DATA_W];
      r_s1_xi    <= bus.stage_i[DATA_W-1:0];
      r_s1_wr    <= bus.w_i[2*TW_W-1:TW_W];
      r_s1_wi    <= bus.w_i[TW_W-1:0];
      r_s2_valid <= r_s1_valid;
      r_s2_conj  <= r_s1_conj;
      r_s2_rr    <= w_xr_e * w_wr_e;
      r_s2_ii    <= w_xi_e * w_wi_e;
      r_s2_ri    <= w_xr_e * w_wi_e;
      r_s2_ir    <= w_xi_e * w_wr_e;
      r_s3_valid <= r_s2_valid;
      r_s3_re    <= w_re;
      r_s3_im    <= w_im;
      r_s4_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_out_re <= w_sc_re[OUT_W-1:0];
        r_out_im <= w_sc_im[OUT_W-1:0];
      end
    end
  end

  // A fresh overflow wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              r_ovf <= 1'b0;
    else if (w_new_ovf)      r_ovf <= 1'b1;
    else if (bus.ovf_clr_i)  r_ovf <= 1'b0;
  end
endmodule

// File: tb/tb_cplx_twiddle_mult.sv
// Bench for cplx_twiddle_mult: a rounding/saturating instance and a
// truncating/wrapping instance driven in lockstep against an arithmetic model.
module tb_cplx_twiddle_mult;
  localparam int DATA_W  = 25;
  localparam int TW_W    = 18;
  localparam int TW_FRAC = 16;
  localparam int OUT_W   = 25;

  logic clk_i;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drv_done;
  logic [2*OUT_W-1:0] held;
  logic [2*OUT_W-1:0] exp_q_a[$];
  logic [2*OUT_W-1:0] exp_q_b[$];

  cplx_twiddle_mult_if #(.DATA_W(DATA_W), .TW_W(TW_W), .OUT_W(OUT_W)) bus_a ();
  cplx_twiddle_mult_if #(.DATA_W(DATA_W), .TW_W(TW_W), .OUT_W(OUT_W)) bus_b ();

  cplx_twiddle_mult #(
    .DATA_W(DATA_W), .TW_W(TW_W), .TW_FRAC(TW_FRAC), .OUT_W(OUT_W), .ROUND_EN(1), .SAT_EN(1)
  ) u_dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_a));

  cplx_twiddle_mult #(
    .DATA_W(DATA_W), .TW_W(TW_W), .TW_FRAC(TW_FRAC), .OUT_W(OUT_W), .ROUND_EN(0), .SAT_EN(0)
  ) u_dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_b));

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [OUT_W-1:0] ref_scale(input longint v, input bit rnd, input bit sat);
    longint maxv, minv, q;
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -(longint'(1) << (OUT_W - 1));
    if (rnd) v = v + (longint'(1) << (TW_FRAC - 1));
    q = v >>> TW_FRAC;
    if (sat && q > maxv) q = maxv;
    else if (sat && q < minv) q = minv;
    return q[OUT_W-1:0];
  endfunction

  function automatic logic [2*OUT_W-1:0] ref_mult(input longint xr, input longint xi,
      input longint wr, input longint wi, input bit cj, input bit rnd, input bit sat);
    longint re, im;
    if (cj) wi = -wi;
    re = xr * wr - xi * wi;
    im = xr * wi + xi * wr;
    return {ref_scale(re, rnd, sat), ref_scale(im, rnd, sat)};
  endfunction

  function automatic logic [2*OUT_W-1:0] cpk(input longint re, input longint im);
    logic [63:0] a, b;
    a = re;
    b = im;
    return {a[OUT_W-1:0], b[OUT_W-1:0]};
  endfunction

  // driver tasks
  task automatic set_inputs(input longint xr, input longint xi, input longint wr,
      input longint wi, input logic cj, input logic vld);
    bus_a.stage_i      = {DATA_W'(xr), DATA_W'(xi)};
    bus_a.w_i          = {TW_W'(wr), TW_W'(wi)};
    bus_a.conj_i       = cj;
    bus_a.data_valid_i = vld;
    bus_b.stage_i      = {DATA_W'(xr), DATA_W'(xi)};
    bus_b.w_i          = {TW_W'(wr), TW_W'(wi)};
    bus_b.conj_i       = cj;
    bus_b.data_valid_i = vld;
  endtask

  task automatic set_ready(input logic r);
    bus_a.data_ready_i = r;
    bus_b.data_ready_i = r;
  endtask

  task automatic set_clr(input logic c);
    bus_a.ovf_clr_i = c;
    bus_b.ovf_clr_i = c;
  endtask

  task automatic send(input longint xr, input longint xi, input longint wr, input longint wi,
      input logic cj, input logic [2*OUT_W-1:0] ea, input logic [2*OUT_W-1:0] eb);
    logic acc;
    int   guard;
    guard = 0;
    set_inputs(xr, xi, wr, wi, cj, 1'b1);
    do begin
      @(negedge clk_i);
      acc = bus_a.data_ready_o;
      if (acc) begin
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
      end
      @(posedge clk_i); #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    bus_a.data_valid_i = 1'b0;
    bus_b.data_valid_i = 1'b0;
  endtask

  task automatic send_rand();
    logic signed [DATA_W-1:0] xr, xi;
    logic signed [TW_W-1:0]   wr, wi;
    logic                     cj;
    xr = DATA_W'($urandom);
    xi = DATA_W'($urandom);
    wr = TW_W'($urandom);
    wi = TW_W'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      xr = DATA_W'($urandom_range(0, 2000)) - DATA_W'(1000);
      xi = DATA_W'($urandom_range(0, 2000)) - DATA_W'(1000);
    end
    cj = 1'($urandom_range(0, 1));
    send(xr, xi, wr, wi, cj, ref_mult(xr, xi, wr, wi, cj, 1, 1), ref_mult(xr, xi, wr, wi, cj, 0, 0));
  endtask

  task automatic latency_test(input string tag, input longint xr, input longint xi,
      input longint wr, input longint wi, input logic cj,
      input logic [2*OUT_W-1:0] ea, input logic [2*OUT_W-1:0] eb);
    int cyc;
    exp_q_a.push_back(ea);
    exp_q_b.push_back(eb);
    set_inputs(xr, xi, wr, wi, cj, 1'b1);
    check({tag, "_accept"}, 64'(bus_a.data_ready_o), 64'd1);
    @(posedge clk_i); #1;
    bus_a.data_valid_i = 1'b0;
    bus_b.data_valid_i = 1'b0;
    cyc = 1;
    while (!bus_a.data_valid_o && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check(tag, 64'(cyc), 64'd4);
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && g < 200) begin
      @(posedge clk_i); #1;
      g++;
    end
    check(tag, 64'(exp_q_a.size() + exp_q_b.size()), 64'd0);
  endtask

  // scoreboard
  always @(negedge clk_i) begin
    if (rst_i && bus_a.data_valid_o && bus_a.data_ready_i) begin
      if (exp_q_a.size() == 0) check("unexpected_out_a", 64'(bus_a.butterfly_stage_o), 64'hdead);
      else check("out_a", 64'(bus_a.butterfly_stage_o), 64'(exp_q_a.pop_front()));
    end
    if (rst_i && bus_b.data_valid_o && bus_b.data_ready_i) begin
      if (exp_q_b.size() == 0) check("unexpected_out_b", 64'(bus_b.butterfly_stage_o), 64'hdead);
      else check("out_b", 64'(bus_b.butterfly_stage_o), 64'(exp_q_b.pop_front()));
    end
  end

  initial begin
    rst_i = 1'b0;
    set_inputs(0, 0, 0, 0, 1'b0, 1'b0);
    set_ready(1'b1);
    set_clr(1'b0);
    repeat (3) @(posedge clk_i); #1;
    check("rst_valid", 64'(bus_a.data_valid_o), 64'd0);
    check("rst_ready", 64'(bus_a.data_ready_o), 64'd1);
    check("rst_out", 64'(bus_a.butterfly_stage_o), 64'd0);
    check("rst_ovf", 64'(bus_a.ovf_o), 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    latency_test("latency_unity", 2, 1, 'h10000, 0, 1'b0, cpk(2, 1), cpk(2, 1));
    wait_drain("drain_unity");

    send(0, 1, 0, 'h10000, 1'b0, cpk(-1, 0), cpk(-1, 0));
    send(0, 1, 0, 'h10000, 1'b1, cpk(1, 0), cpk(1, 0));
    send(3, 0, 'h08000, 0, 1'b0, cpk(2, 0), cpk(1, 0));
    send(-3, 0, 'h08000, 0, 1'b0, cpk(-1, 0), cpk(-2, 0));
    wait_drain("drain_round");
    check("ovf_quiet", 64'(bus_a.ovf_o), 64'd0);

    send(-(longint'(1) << 24), 0, 'h30000, 0, 1'b0, cpk((longint'(1) << 24) - 1, 0), cpk(-(longint'(1) << 24), 0));
    wait_drain("drain_sat");
    check("ovf_set_a", 64'(bus_a.ovf_o), 64'd1);
    check("ovf_set_b", 64'(bus_b.ovf_o), 64'd1);
    repeat (5) @(posedge clk_i); #1;
    check("ovf_sticky", 64'(bus_a.ovf_o), 64'd1);
    set_clr(1'b1);
    @(posedge clk_i); #1;
    set_clr(1'b0);
    check("ovf_clr", 64'(bus_a.ovf_o), 64'd0);

    // clear held high while a new overflow lands
    set_clr(1'b1);
    send(-(longint'(1) << 24), 0, 'h30000, 0, 1'b0, cpk((longint'(1) << 24) - 1, 0), cpk(-(longint'(1) << 24), 0));
    for (int g = 0; g < 20 && !bus_a.data_valid_o; g++) begin
      @(posedge clk_i); #1;
    end
    check("ovf_set_prio", 64'(bus_a.ovf_o), 64'd1);
    set_clr(1'b0);
    wait_drain("drain_prio");
    set_clr(1'b1);
    @(posedge clk_i); #1;
    set_clr(1'b0);

    // backpressure: eight back-to-back samples, three stalled cycles mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (6) @(posedge clk_i); #1;
        set_ready(1'b0);
        @(negedge clk_i);
        held = bus_a.butterfly_stage_o;
        check("bp_ready_low", 64'(bus_a.data_ready_o), 64'd0);
        repeat (2) begin
          @(negedge clk_i);
          check("bp_ready_low", 64'(bus_a.data_ready_o), 64'd0);
          check("bp_hold", 64'(bus_a.butterfly_stage_o), 64'(held));
        end
        @(posedge clk_i); #1;
        set_ready(1'b1);
      end
    join
    wait_drain("drain_bp");

    // random stream with random gaps and random backpressure
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          set_ready(1'($urandom_range(0, 3) != 0));
          @(posedge clk_i); #1;
        end
        set_ready(1'b1);
      end
    join
    wait_drain("drain_random");

    // reset with three samples in flight
    for (int i = 0; i < 3; i++) send_rand();
    rst_i = 1'b0;
    #1;
    check("midrst_valid", 64'(bus_a.data_valid_o), 64'd0);
    check("midrst_ready", 64'(bus_a.data_ready_o), 64'd1);
    check("midrst_out", 64'(bus_b.butterfly_stage_o), 64'd0);
    exp_q_a.delete();
    exp_q_b.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (8) @(posedge clk_i); #1;
    check("post_rst_idle", 64'(bus_a.data_valid_o), 64'd0);
    latency_test("latency_post_rst", 5, -7, 'h10000, 'h04000, 1'b0,
                 ref_mult(5, -7, 'h10000, 'h04000, 1'b0, 1, 1),
                 ref_mult(5, -7, 'h10000, 'h04000, 1'b0, 0, 0));
    wait_drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cplx_twiddle_mult.md
CPLX_TWIDDLE_MULT -- requirements
Module: cplx_twiddle_mult

Interface
REQ-001 SHALL have parameter DATA_W, default 25, giving the width of each real/imag input component (two's complement).
REQ-002 SHALL have parameter TW_W, default 18, giving the width of each twiddle component (two's complement).
REQ-003 SHALL have parameter TW_FRAC, default 16, giving the number of fractional bits in the twiddle (Q2.16 at default).
REQ-004 SHALL have parameter OUT_W, default 25, giving the width of each output component.
REQ-005 SHALL have parameter ROUND_EN, default 1, where 1 = round-half-up and 0 = truncate.
REQ-006 SHALL have parameter SAT_EN, default 1, where 1 = saturate on overflow and 0 = wrap.
REQ-007 clk_i  in  1  single clock; all state on rising edge.
REQ-008 rst_i  in  1  reset, asynchronous assert, active-low.
REQ-009 stage_i  in  2*DATA_W  input sample, {re, im}, re in upper half.
REQ-010 w_i  in  2*TW_W  twiddle, {re, im}, re in upper half.
REQ-011 conj_i  in  1  1 = multiply by conj(w_i) (IFFT mode); sampled with stage_i.
REQ-012 data_valid_i  in  1  input sample valid.
REQ-013 data_ready_o  out  1  block accepts input this cycle.
REQ-014 butterfly_stage_o  out  2*OUT_W  product, {re, im}.
REQ-015 data_valid_o  out  1  output valid.
REQ-016 data_ready_i  in  1  downstream accepts output.
REQ-017 ovf_o  out  1  sticky overflow flag.
REQ-018 ovf_clr_i  in  1  synchronous clear of ovf_o.

Function
REQ-019 SHALL compute y = x*w, or y = x*conj(w) when conj_i=1: re = xr*wr - xi*wi, im = xr*wi + xi*wr, with the sign of the wi terms inverted in conj mode.
REQ-020 SHALL use four signed products of full width DATA_W+TW_W, and sums of width DATA_W+TW_W+1 with no intermediate truncation.
REQ-021 SHALL scale each sum by arithmetic right shift of TW_FRAC bits.
REQ-022 With ROUND_EN=1, SHALL add 2^(TW_FRAC-1) before the shift (round half toward +inf); with ROUND_EN=0, SHALL truncate toward -inf.
REQ-023 With SAT_EN=1, SHALL clamp a scaled value outside the OUT_W signed range to +2^(OUT_W-1)-1 or -2^(OUT_W-1); with SAT_EN=0, SHALL keep the low OUT_W bits.
REQ-024 SHALL be a 4-stage pipeline: S1 input register, S2 products, S3 sums, S4 round/saturate output register; latency 4 cycles from accepted input to data_valid_o with no stall.
REQ-025 SHALL carry a valid bit and the conj bit alongside the data through every stage.
REQ-026 SHALL use a global stall: stall = data_valid_o & ~data_ready_i; data_ready_o = ~stall.
REQ-027 While stalled, SHALL hold all pipeline stages, including valid bits, and keep butterfly_stage_o stable.
REQ-028 SHALL accept an input only when data_valid_i & data_ready_o; stage_i, w_i and conj_i are don't-care otherwise.
REQ-029 SHALL sustain throughput of 1 sample/cycle while data_ready_i=1; bubbles propagate and are not collapsed.
REQ-030 SHALL set ovf_o when S4 saturates or wraps either component of a valid sample; ovf_o is sticky.
REQ-031 If ovf_clr_i and a new overflow occur in the same cycle, SHALL give the set priority, so ovf_o = 1.
REQ-032 SHALL update output data only when the S4 valid bit advances; data on invalid cycles holds its last value.

Reset
REQ-033 On rst_i=0, SHALL asynchronously clear all valid bits, butterfly_stage_o and ovf_o to 0; data_valid_o = 0 and data_ready_o = 1 immediately.
REQ-034 Reset mid-stream SHALL discard in-flight samples; the first accepted input after rst_i rises appears 4 cycles later.

Verification
REQ-035 x=(2,1), w=(1.0=0x10000, 0), conj=0, ready=1 -> (2,1) with data_valid_o exactly 4 cycles after acceptance.
REQ-036 x=(0,1), w=(0, 0x10000): conj=0 -> (-1,0); conj=1 -> (1,0).
REQ-037 Rounding: x=(3,0), w=(0x08000, 0) -> re=2 with ROUND_EN=1 and 1 with ROUND_EN=0; x=(-3,0) -> re=-1 and -2 respectively.
REQ-038 Saturation: x=(-2^24, 0), w=(-1.0=0x30000, 0) -> re=2^24-1, ovf_o=1 held until ovf_clr_i; SAT_EN=0 -> re=-2^24.
REQ-039 Backpressure: stream 8 samples and drop data_ready_i for 3 cycles mid-stream -> data_ready_o=0 during the stall, outputs held, all 8 results in order, none lost or duplicated.
REQ-040 Assert rst_i with 3 samples in flight -> data_valid_o=0 at once; no stale outputs after release.
